// File: rtl/adder_arbiter.sv
// Round-robin front end for one shared registered nibble adder: grants one of two
// requesters, captures its operands, sequences the adder and returns the result.
module adder_arbiter #(
    parameter int W         = 4,
    parameter int FIRST_PRI = 0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Req0,
    input  logic [W-1:0] A0,
    input  logic [W-1:0] B0,
    output logic         Gnt0,
    output logic         Done0,
    input  logic         Req1,
    input  logic [W-1:0] A1,
    input  logic [W-1:0] B1,
    output logic         Gnt1,
    output logic         Done1,
    output logic [W-1:0] Sum,
    output logic         Overflow,
    output logic [W-1:0] Add_A,
    output logic [W-1:0] Add_B,
    output logic         Add_En,
    input  logic [W-1:0] Add_Sum,
    input  logic         Add_Overflow
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic LAST_INIT = (FIRST_PRI == 0) ? 1'b1 : 1'b0;

    state_t state;
    logic   last;
    logic   sel;
    logic   winner;

    // A sole requester wins outright; on a tie the one not served last wins.
    always_comb begin
        winner = Req1 & (~Req0 | ~last);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            last     <= LAST_INIT;
            sel      <= 1'b0;
            Gnt0     <= 1'b0;
            Gnt1     <= 1'b0;
            Done0    <= 1'b0;
            Done1    <= 1'b0;
            Add_En   <= 1'b0;
            Add_A    <= '0;
            Add_B    <= '0;
            Sum      <= '0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done0 <= 1'b0;
                    Done1 <= 1'b0;
                    if (Req0 | Req1) begin
                        Gnt0   <= ~winner;
                        Gnt1   <= winner;
                        Add_A  <= winner ? A1 : A0;
                        Add_B  <= winner ? B1 : B0;
                        last   <= winner;
                        sel    <= winner;
                        Add_En <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The adder captures Add_A/Add_B on this edge.
                    Gnt0   <= 1'b0;
                    Gnt1   <= 1'b0;
                    Add_En <= 1'b0;
                    state  <= RESP;
                end
                RESP: begin
                    Sum      <= Add_Sum;
                    Overflow <= Add_Overflow;
                    Done0    <= ~sel;
                    Done1    <= sel;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized scoreboard bench for adder_arbiter, driving a behavioural copy of the
// shared registered adder.
module tb_adder_arbiter;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Req0 = 1'b0, Req1 = 1'b0;
    logic [3:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic       Gnt0, Gnt1, Done0, Done1;
    logic [3:0] Sum;
    logic       Overflow;
    logic [3:0] Add_A, Add_B;
    logic       Add_En;
    logic [3:0] Add_Sum = '0;
    logic       Add_Overflow = 1'b0;

    adder_arbiter #(.W(4), .FIRST_PRI(0)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .A0(A0), .B0(B0), .Gnt0(Gnt0), .Done0(Done0),
        .Req1(Req1), .A1(A1), .B1(B1), .Gnt1(Gnt1), .Done1(Done1),
        .Sum(Sum), .Overflow(Overflow),
        .Add_A(Add_A), .Add_B(Add_B), .Add_En(Add_En),
        .Add_Sum(Add_Sum), .Add_Overflow(Add_Overflow)
    );

    always #5 Clk = ~Clk;

    // Shared adder: captures when enabled, holds otherwise, no reset.
    always @(posedge Clk) begin
        if (Add_En) {Add_Overflow, Add_Sum} <= {1'b0, Add_A} + {1'b0, Add_B};
    end

    typedef struct {
        int who;
        int sum;
        int ovf;
    } exp_t;

    exp_t dq[$];
    int   gq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   gcyc = -100;
    int   model_last = 1;

    always @(posedge Clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: grant order, Add_En alignment, Done latency and results.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (Gnt0 && Gnt1) chk("both gnt", 1, 0);
            if (Done0 && Done1) chk("both done", 1, 0);
            if (Add_En || Gnt0 || Gnt1) chk("add_en with gnt", int'(Add_En), int'(Gnt0 | Gnt1));
            if (Gnt0 ^ Gnt1) begin
                gcyc = cyc;
                if (gq.size() == 0) chk("unexpected gnt", 1, 0);
                else chk("gnt who", Gnt1 ? 1 : 0, gq.pop_front());
            end
            if (Done0 ^ Done1) begin
                chk("done latency", cyc - gcyc, 2);
                if (dq.size() == 0) chk("unexpected done", 1, 0);
                else begin
                    exp_t e;
                    e = dq.pop_front();
                    chk("done who", Done1 ? 1 : 0, e.who);
                    chk("sum", int'(Sum), e.sum);
                    chk("overflow", int'(Overflow), e.ovf);
                end
            end
        end
    end

    function automatic exp_t mk(input int who, input int a, input int b);
        exp_t e;
        e.who = who;
        e.sum = (a + b) % 16;
        e.ovf = (a + b) / 16;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst gnt", int'({Gnt1, Gnt0}), 0);
        chk("rst done", int'({Done1, Done0}), 0);
        chk("rst add_en", int'(Add_En), 0);
        chk("rst sum", int'({Overflow, Sum}), 0);
        chk("rst add ops", int'({Add_A, Add_B}), 0);
        dq.delete();
        gq.delete();
        model_last = 1;
        Reset = 1'b0;
    endtask

    // Present one request set; each client drops Req and scrambles operands on its Gnt.
    task automatic issue(input int mask, input int a0, input int b0, input int a1, input int b1);
        bit p0, p1;
        int w;
        p0 = mask[0];
        p1 = mask[1];
        if (mask == 3) begin
            w = 1 - model_last;
            gq.push_back(w);
            dq.push_back(w == 0 ? mk(0, a0, b0) : mk(1, a1, b1));
            gq.push_back(1 - w);
            dq.push_back(w == 0 ? mk(1, a1, b1) : mk(0, a0, b0));
        end else begin
            w = (mask == 2) ? 1 : 0;
            gq.push_back(w);
            dq.push_back(w == 0 ? mk(0, a0, b0) : mk(1, a1, b1));
            model_last = w;
        end
        A0 = 4'(a0); B0 = 4'(b0); A1 = 4'(a1); B1 = 4'(b1);
        Req0 = p0;
        Req1 = p1;
        for (int t = 0; t < 40 && (p0 || p1); t++) begin
            @(negedge Clk);
            if (p0 && Gnt0) begin
                p0 = 0; Req0 = 1'b0; A0 = 4'($urandom); B0 = 4'($urandom);
            end
            if (p1 && Gnt1) begin
                p1 = 0; Req1 = 1'b0; A1 = 4'($urandom); B1 = 4'($urandom);
            end
        end
        if (p0 || p1) begin
            chk("grant timeout", 1, 0);
            Req0 = 1'b0;
            Req1 = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int w;
        bit seen;
        do_reset();

        // Directed cases.
        issue(1, 3, 4, 0, 0);
        issue(2, 0, 0, 9, 8);
        do_reset();
        issue(3, 1, 2, 5, 5);
        issue(1, 15, 1, 0, 0);
        repeat (4) @(negedge Clk);

        // Both requesters held continuously: grants alternate every 3 cycles.
        A0 = 4'd6; B0 = 4'd7; A1 = 4'd12; B1 = 4'd9;
        w = 1 - model_last;
        for (int k = 0; k < 6; k++) begin
            gq.push_back(w);
            dq.push_back(w == 0 ? mk(0, 6, 7) : mk(1, 12, 9));
            model_last = w;
            w = 1 - w;
        end
        Req0 = 1'b1;
        Req1 = 1'b1;
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            seen = 0;
            for (int t = 0; t < 10 && !seen; t++) begin
                @(negedge Clk);
                if (Gnt0 || Gnt1) seen = 1;
            end
            chk("rr grant seen", int'(seen), 1);
            if (prev >= 0) chk("rr spacing", cyc - prev, 3);
            prev = cyc;
        end
        Req0 = 1'b0;
        Req1 = 1'b0;
        repeat (4) @(negedge Clk);

        // Reset landing on the RESP edge discards the op.
        gq.push_back(0);
        A0 = 4'd7; B0 = 4'd7;
        Req0 = 1'b1;
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge Clk);
            if (Gnt0) seen = 1;
        end
        chk("pre-reset gnt", int'(seen), 1);
        Req0 = 1'b0;
        @(negedge Clk);
        chk("in resp add_en", int'(Add_En), 0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("mid-op rst done", int'({Done1, Done0}), 0);
        chk("mid-op rst outs", int'({Sum, Overflow, Add_A, Add_B, Add_En, Gnt0, Gnt1}), 0);
        dq.delete();
        gq.delete();
        model_last = 1;
        Reset = 1'b0;
        issue(1, 2, 2, 0, 0);

        // Randomized traffic.
        for (int r = 0; r < 60; r++) begin
            issue(int'($urandom_range(1, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) @(negedge Clk);
        end

        repeat (8) @(negedge Clk);
        chk("done queue drained", dq.size(), 0);
        chk("gnt queue drained", gq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
